mul4_share_ctrl: RTL and testbench

- Shares one 4x4 shift-add multiplier core (START/A/B in, P/READY out) among N requesters.
- Round-robin arbitration grants one requester, then the block sequences the core: loads operands, pulses START, waits for READY, captures the 8-bit product and returns it with a one-cycle DONE.
- Sits between the request-side logic and the multiplier core; it is the only driver of the core's START and operand inputs.

---
 rtl/mul4_share_pkg.sv | 25 ++
 rtl/mul4_share_ctrl_if.sv | 31 +++
 rtl/mul4_share_ctrl_rr_arb.sv | 32 +++
 rtl/mul4_share_ctrl.sv | 134 +++++++++++++
 tb/tb_mul4_share_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul4_share_pkg.sv
// Shared types, widths and sizing helpers for the shared 4x4 multiplier controller.
package mul4_share_pkg;

  localparam int OP_W         = 4;
  localparam int PROD_W       = 8;
  localparam int TIMEOUT_DFLT = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    RUN,
    FIN
  } state_t;

  // Phase counter must reach TIMEOUT-1, which dominates START_CYC and MIN_WAIT.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul4_share_ctrl_if.sv
// Requester-side and core-side signal bundle of the shared multiplier controller.
interface mul4_share_ctrl_if #(
  parameter int N = 4
);
  import mul4_share_pkg::*;

  logic [N-1:0]      REQ;
  logic [OP_W*N-1:0] REQ_A;
  logic [OP_W*N-1:0] REQ_B;
  logic [N-1:0]      GNT;
  logic [N-1:0]      DONE;
  logic [PROD_W-1:0] RESULT;
  logic              ERR;
  logic              BUSY;
  logic              M_START;
  logic [OP_W-1:0]   M_A;
  logic [OP_W-1:0]   M_B;
  logic [PROD_W-1:0] M_P;
  logic              M_READY;

  modport master (
    input  REQ, REQ_A, REQ_B, M_P, M_READY,
    output GNT, DONE, RESULT, ERR, BUSY, M_START, M_A, M_B
  );

  modport slave (
    output REQ, REQ_A, REQ_B, M_P, M_READY,
    input  GNT, DONE, RESULT, ERR, BUSY, M_START, M_A, M_B
  );

endinterface

// File: rtl/mul4_share_ctrl_rr_arb.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arb
  import mul4_share_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mul4_share_ctrl.sv
// Shares one 4x4 multiplier core among N requesters: round-robin grant, START/READY
// sequencing with stale-READY masking and a RUN timeout, one-cycle DONE per operation.
module mul4_share_ctrl
  import mul4_share_pkg::*;
#(
  parameter int N         = 4,
  parameter int START_CYC = 1,
  parameter int MIN_WAIT  = 2,
  parameter int TIMEOUT   = TIMEOUT_DFLT
) (
  input logic               CK,
  input logic               RST,
  mul4_share_ctrl_if.master bus
);

  localparam int IDX_W = idx_width(N);
  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [N-1:0]      gnt_q;
  logic [N-1:0]      done_q;
  logic [PROD_W-1:0] result_q;
  logic              err_q;
  logic              start_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;

  logic [N-1:0]      arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [OP_W-1:0]   sel_a_d;
  logic [OP_W-1:0]   sel_b_d;

  rr_arb #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req_i (bus.REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) begin
        sel_a_d = bus.REQ_A[i*OP_W +: OP_W];
        sel_b_d = bus.REQ_B[i*OP_W +: OP_W];
      end
    end
  end

  // Operands are captured once at grant and stay frozen until the next grant.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.REQ) begin
            owner_q <= arb_idx;
            gnt_q   <= arb_gnt;
            a_q     <= sel_a_d;
            b_q     <= sel_b_d;
            start_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q == CNT_W'(START_CYC - 1)) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(MIN_WAIT - 1)) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (bus.M_READY) begin
            result_q <= bus.M_P;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            state_q  <= FIN;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= gnt_q;
            state_q  <= FIN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIN: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          gnt_q   <= '0;
          ptr_q   <= (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.DONE    = done_q;
  assign bus.RESULT  = result_q;
  assign bus.ERR     = err_q;
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.M_START = start_q;
  assign bus.M_A     = a_q;
  assign bus.M_B     = b_q;

endmodule

// File: tb/tb_mul4_share_ctrl.sv
// Directed and randomized bench for mul4_share_ctrl with a behavioural multiplier core
// and a queue-free scoreboard of pending requests, operands and the round-robin pointer.
module tb_mul4_share_ctrl;

  localparam int N         = 4;
  localparam int START_CYC = 1;
  localparam int MIN_WAIT  = 2;
  localparam int TIMEOUT   = 32;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  mul4_share_ctrl_if #(.N(N)) bus ();

  mul4_share_ctrl #(
    .N(N), .START_CYC(START_CYC), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // Behavioural core: READY once core_lat cycles have elapsed since the last START.
  int       core_age = 1000;
  int       core_lat = 5;
  bit       stuck0   = 1'b0;
  bit       stale_en = 1'b0;
  logic [3:0] core_a = '0;
  logic [3:0] core_b = '0;

  always @(posedge CK) begin
    if (bus.M_START) begin
      core_age <= 0;
      core_a   <= bus.M_A;
      core_b   <= bus.M_B;
    end else if (core_age < 1000) begin
      core_age <= core_age + 1;
    end
  end

  assign bus.M_READY = !stuck0 && ((core_age >= core_lat) || (stale_en && core_age < MIN_WAIT));
  assign bus.M_P     = (core_age >= core_lat) ? ({4'b0, core_a} * {4'b0, core_b}) : 8'hAA;

  // Scoreboard
  bit [N-1:0] pend = '0;
  logic [3:0] opa [N];
  logic [3:0] opb [N];
  int         ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_req(input int i, input logic [3:0] a, input logic [3:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
    bus.REQ_A[i*4 +: 4] = a;
    bus.REQ_B[i*4 +: 4] = b;
    bus.REQ[i] = 1'b1;
  endtask

  function automatic int exp_owner();
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic serve_one(input bit tmo, input bit scramble, input bit drop, input bit late);
    int   e, g, nstart, k, lat_exp;
    bit   got, stable;
    logic [7:0] res_exp;
    e   = exp_owner();
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CK);
      if (bus.GNT != '0) got = 1'b1;
    end
    check("grant_seen", got, 1);
    if (got) begin
      g = cyc;
      check("gnt_owner", bus.GNT, 1 << e);
      check("m_a_grant", bus.M_A, opa[e]);
      check("m_b_grant", bus.M_B, opb[e]);
      check("m_start_grant", bus.M_START, 1);
      check("busy_grant", bus.BUSY, 1);
      if (scramble) begin
        bus.REQ_A[e*4 +: 4] = ~opa[e];
        bus.REQ_B[e*4 +: 4] = ~opb[e];
      end
      if (drop) bus.REQ[e] = 1'b0;
      if (late) begin
        k = $urandom_range(N-1, 0);
        if (!pend[k]) add_req(k, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      end
      nstart = 1;
      stable = 1'b1;
      got    = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge CK);
        if (bus.DONE != '0) got = 1'b1;
        else begin
          nstart += int'(bus.M_START);
          if (bus.GNT !== 4'(1 << e) || bus.M_A !== opa[e] || bus.M_B !== opb[e]) stable = 1'b0;
        end
      end
      check("done_seen", got, 1);
      if (got) begin
        lat_exp = tmo ? (START_CYC + MIN_WAIT + TIMEOUT)
                      : (START_CYC + ((core_lat > MIN_WAIT) ? core_lat : MIN_WAIT) + 1);
        res_exp = tmo ? 8'h00 : 8'(opa[e] * opb[e]);
        check("start_cycles", nstart, START_CYC);
        check("frozen_ops_gnt", stable, 1);
        check("done_latency", cyc - g, lat_exp);
        check("done_vec", bus.DONE, 1 << e);
        check("result", bus.RESULT, res_exp);
        check("err", bus.ERR, tmo);
        pend[e]    = 1'b0;
        ptr        = (e + 1) % N;
        bus.REQ[e] = 1'b0;
        @(negedge CK);
        check("idle_gap", {bus.GNT, bus.DONE, bus.BUSY, bus.ERR}, 0);
        check("result_hold", bus.RESULT, res_exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    RST       = 1'b1;
    bus.REQ   = '0;
    bus.REQ_A = '0;
    bus.REQ_B = '0;
    repeat (3) @(negedge CK);
    check("rst_gnt", bus.GNT, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_result", bus.RESULT, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_m_start", bus.M_START, 0);
    check("rst_m_a", bus.M_A, 0);
    check("rst_m_b", bus.M_B, 0);
    RST = 1'b0;
    @(negedge CK);

    // Single request on requester 0: 3*5
    core_lat = 5;
    add_req(0, 4'd3, 4'd5);
    serve_one(0, 0, 0, 0);
    check("single_result_const", bus.RESULT, 8'h0F);

    // Maximum operands on requester 2
    add_req(2, 4'd15, 4'd15);
    serve_one(0, 0, 0, 0);
    check("max_result_const", bus.RESULT, 8'hE1);

    // Requester 3 brings the pointer back to 0, then 0 and 2 contend
    add_req(3, 4'd7, 4'd9);
    serve_one(0, 0, 0, 0);
    add_req(0, 4'd6, 4'd11);
    add_req(2, 4'd13, 4'd2);
    serve_one(0, 0, 0, 0);
    serve_one(0, 0, 0, 0);

    // READY asserted with a bogus product while the controller must ignore it
    stale_en = 1'b1;
    core_lat = 4;
    add_req(1, 4'd9, 4'd14);
    serve_one(0, 0, 0, 0);
    stale_en = 1'b0;

    // Core never answers; the next request must still complete normally
    stuck0 = 1'b1;
    add_req(2, 4'd12, 4'd12);
    serve_one(1, 0, 0, 0);
    stuck0 = 1'b0;
    core_lat = 3;
    add_req(3, 4'd10, 4'd4);
    serve_one(0, 0, 0, 0);

    // Owner changes operands and drops REQ mid-operation
    add_req(0, 4'd5, 4'd8);
    serve_one(0, 1, 1, 1);
    for (int s = 0; s < 8 && pend != '0; s++) serve_one(0, 0, 0, 0);

    // Randomized rounds
    for (int r = 0; r < 15; r++) begin
      core_lat = $urandom_range(10, 1);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1, 0) == 1)
          add_req(i, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      end
      if (pend == '0) add_req($urandom_range(N-1, 0), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      for (int s = 0; s < 16 && pend != '0; s++)
        serve_one(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset mid-RUN: pointer is set to 2 first so a stale pointer would pick requester 3
    core_lat = 3;
    add_req(1, 4'd2, 4'd3);
    serve_one(0, 0, 0, 0);
    core_lat = 20;
    add_req(2, 4'd4, 4'd4);
    saw_done = 1'b0;
    for (int t = 0; t < 20 && bus.GNT == '0; t++) @(negedge CK);
    check("rst_test_grant", bus.GNT, 4'b0100);
    repeat (5) @(negedge CK);
    check("rst_test_in_run", bus.BUSY, 1);
    RST     = 1'b1;
    bus.REQ = '0;
    pend    = '0;
    ptr     = 0;
    @(negedge CK);
    RST = 1'b0;
    check("midrst_gnt", bus.GNT, 0);
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_m_start", bus.M_START, 0);
    check("midrst_done", bus.DONE, 0);
    for (int t = 0; t < 25; t++) begin
      @(negedge CK);
      if (bus.DONE != '0) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    core_lat = 5;
    add_req(1, 4'd11, 4'd7);
    add_req(3, 4'd8, 4'd8);
    serve_one(0, 0, 0, 0);
    serve_one(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
